// File: rtl/serial_track_adder_if.sv
// Bundles the control inputs and observation outputs of serial_track_adder.
// The master drives ops and serial operands; the slave (the adder) returns track state.
interface serial_track_adder_if #(
    parameter int WORD_BITS = 29
);
    localparam int IDX_W = $clog2(WORD_BITS);

    logic             SYNC;
    logic [1:0]       OP;
    logic             USE_ALT;
    logic             ADDEND_IN;
    logic             LOAD_IN;
    logic             BLOCK_TOP;
    logic             OVF_CLR;
    logic             TRK_OUT;
    logic             SUM_OUT;
    logic [IDX_W-1:0] BIT_IDX;
    logic             WORD_END;
    logic             CARRY_OUT;
    logic             OVF;

    modport master (
        output SYNC, OP, USE_ALT, ADDEND_IN, LOAD_IN, BLOCK_TOP, OVF_CLR,
        input  TRK_OUT, SUM_OUT, BIT_IDX, WORD_END, CARRY_OUT, OVF
    );

    modport slave (
        input  SYNC, OP, USE_ALT, ADDEND_IN, LOAD_IN, BLOCK_TOP, OVF_CLR,
        output TRK_OUT, SUM_OUT, BIT_IDX, WORD_END, CARRY_OUT, OVF
    );
endinterface

// File: rtl/serial_track_adder.sv
// Recirculating serial word track with a bit-serial adder applying HOLD/ADD/SUB/LOAD per word time.
// One bit per cycle; a word written in word time k is read back in word time k+1; no backpressure.
module serial_track_adder #(
    parameter int                   WORD_BITS = 29,
    parameter int                   WIN_LO    = 2,
    parameter int                   WIN_HI    = 28,
    parameter int                   ALT_HI    = 21,
    parameter logic [WORD_BITS-1:0] INIT      = '0
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    serial_track_adder_if.slave  bus
);
    localparam int IDX_W = $clog2(WORD_BITS);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(WIN_LO);
    localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(WIN_HI);
    localparam logic [IDX_W-1:0] IDX_AHI  = IDX_W'(ALT_HI);

    logic [IDX_W-1:0]     bit_idx;
    logic [1:0]           op_lat;
    logic                 alt_lat;
    logic [WORD_BITS-1:0] track;
    logic                 carry;
    logic                 carry_out;
    logic                 ovf;

    logic [1:0]       eff_op;
    logic             eff_alt;
    logic [IDX_W-1:0] win_hi;
    logic             in_win;
    logic             is_arith;
    logic             trk_bit;
    logic             b_bit;
    logic             c_in;
    logic             sum_bit;
    logic             c_next;
    logic             wr_bit;
    logic             win_end;
    logic             ovf_set;

    // Op and window selection are taken live at bit 0 and held for the rest of the word.
    always_comb begin
        eff_op   = (bit_idx == '0) ? bus.OP : op_lat;
        eff_alt  = (bit_idx == '0) ? bus.USE_ALT : alt_lat;
        win_hi   = eff_alt ? IDX_AHI : IDX_HI;
        in_win   = (bit_idx >= IDX_LO) && (bit_idx <= win_hi);
        is_arith = (eff_op == OP_ADD) || (eff_op == OP_SUB);
        trk_bit  = track[0];
        b_bit    = (eff_op == OP_SUB) ? ~bus.ADDEND_IN : bus.ADDEND_IN;
        // Carry seeds to 1 for SUB so that ~addend + 1 forms the two's complement.
        c_in     = (bit_idx == IDX_LO) ? (eff_op == OP_SUB) : carry;
        sum_bit  = trk_bit ^ b_bit ^ c_in;
        c_next   = (trk_bit & b_bit) | (trk_bit & c_in) | (b_bit & c_in);
        win_end  = is_arith && (bit_idx == win_hi);
        ovf_set  = win_end && ((eff_op == OP_ADD) ? c_next : ~c_next);

        wr_bit = trk_bit;
        case (eff_op)
            OP_HOLD: wr_bit = trk_bit;
            OP_LOAD: wr_bit = bus.LOAD_IN;
            default: wr_bit = in_win ? sum_bit : trk_bit;
        endcase
        if (bus.BLOCK_TOP && (bit_idx == IDX_LAST)) begin
            wr_bit = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            bit_idx   <= '0;
            op_lat    <= OP_HOLD;
            alt_lat   <= 1'b0;
            track     <= INIT;
            carry     <= 1'b0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (bus.SYNC || (bit_idx == IDX_LAST)) begin
                bit_idx <= '0;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (bit_idx == '0) begin
                op_lat  <= bus.OP;
                alt_lat <= bus.USE_ALT;
            end
            track <= {wr_bit, track[WORD_BITS-1:1]};
            if (is_arith && in_win) begin
                carry <= c_next;
            end
            if (win_end) begin
                carry_out <= c_next;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (bus.OVF_CLR) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.TRK_OUT   = track[0];
    assign bus.SUM_OUT   = wr_bit;
    assign bus.BIT_IDX   = bit_idx;
    assign bus.WORD_END  = (bit_idx == IDX_LAST);
    assign bus.CARRY_OUT = carry_out;
    assign bus.OVF       = ovf;
endmodule

// File: doc/serial_track_adder.md
Name: serial_track_adder

Overview:
- Parametrised successor to the command-register track and serial adder in the control gate.
- Holds one recirculating serial word of WORD_BITS bits and runs its own bit-time counter.
- Each word time it performs HOLD, ADD, SUB or LOAD over a configurable bit window.
- Used for N-address increment, relative addressing and other serial counters that previously needed hand-built T-pulse gating.

Parameters:
- WORD_BITS, 29, bits per word and track length; minimum 4.
- WIN_LO, 2, first bit time of the arithmetic window (bit times are 0-based, LSB first).
- WIN_HI, 28, last bit time of the window, inclusive.
- ALT_HI, 21, alternate last bit time, selected by USE_ALT. Constraint: WIN_LO <= ALT_HI <= WIN_HI <= WORD_BITS-1.
- INIT, 0, WORD_BITS-bit track contents after reset; bit i is emitted at bit time i.

Ports:
- CLOCK  in  1  system clock, one bit time per cycle.
- rst  in  1  synchronous, active-high reset.
- SYNC  in  1  forces the bit counter to 0 on the next edge.
- OP  in  2  operation: 00 HOLD, 01 ADD, 10 SUB, 11 LOAD.
- USE_ALT  in  1  window end is ALT_HI instead of WIN_HI.
- ADDEND_IN  in  1  serial addend bit, aligned to BIT_IDX.
- LOAD_IN  in  1  serial load bit, aligned to BIT_IDX.
- BLOCK_TOP  in  1  forces the written bit at bit time WORD_BITS-1 to 0.
- OVF_CLR  in  1  clears OVF.
- TRK_OUT  out  1  current track bit (augend).
- SUM_OUT  out  1  bit being written back this cycle.
- BIT_IDX  out  $clog2(WORD_BITS)  current bit time.
- WORD_END  out  1  high when BIT_IDX == WORD_BITS-1.
- CARRY_OUT  out  1  final window carry of the last completed word.
- OVF  out  1  sticky overflow/borrow flag.

Behaviour:
- Reset (rst high at an edge):
  - BIT_IDX=0, track=INIT, carry=0, latched op=HOLD.
  - CARRY_OUT=0, OVF=0.
  - rst has priority over SYNC and every other input.
- Bit counter:
  - Increments every cycle and wraps WORD_BITS-1 -> 0.
  - SYNC high: next BIT_IDX=0. Any in-progress op is abandoned; written bits already stored remain.
- Op sampling:
  - Effective op = OP when BIT_IDX==0, else the value latched at bit 0.
  - USE_ALT is sampled the same way.
  - OP changes mid-word have no effect.
- Track:
  - WORD_BITS-deep recirculating shift register.
  - TRK_OUT is the bit written exactly WORD_BITS cycles earlier.
  - Latency: a word written in word time k appears on TRK_OUT in word time k+1.
- Window: in_win = WIN_LO <= BIT_IDX <= hi, where hi = USE_ALT ? ALT_HI : WIN_HI.
- Written bit, by op:
  - HOLD: TRK_OUT.
  - LOAD: LOAD_IN at every bit time, window ignored.
  - ADD/SUB outside window: TRK_OUT unchanged; carry is not propagated.
  - ADD/SUB inside window: b = ADDEND_IN (ADD) or ~ADDEND_IN (SUB); sum = TRK_OUT ^ b ^ c; c_next = majority(TRK_OUT, b, c).
- Carry initialisation: at BIT_IDX==WIN_LO, c is taken as 0 for ADD and 1 for SUB, giving two's-complement subtract.
- Window end (BIT_IDX==hi, ADD/SUB only):
  - CARRY_OUT <= c_next on that edge.
  - OVF set if ADD and c_next=1, or SUB and c_next=0 (borrow).
  - OVF set and OVF_CLR in the same cycle: set wins.
  - HOLD/LOAD words leave CARRY_OUT unchanged.
- BLOCK_TOP: when high at BIT_IDX==WORD_BITS-1, the written bit is forced to 0. This is applied after op selection and also applies to LOAD.
- Outputs:
  - SUM_OUT is combinational and equals the bit written this cycle.
  - All other outputs are registered or decoded from registers.

Test Plan:
- Default parameters; after rst, OP=HOLD for 3 words -> TRK_OUT serialises INIT=0 every word; BIT_IDX wraps 28 -> 0; WORD_END pulses every 29 cycles.
- OP=LOAD one word with value 0x0000_0ABC, then OP=ADD with addend 0x4 (bit 2 set) for 5 words -> track reads 0xABC, 0xAC0, 0xAC4, 0xAC8, 0xACC, 0xAD0 in successive words; CARRY_OUT=0; OVF=0.
- Load 0x1FFF_FFFC, then ADD 0x4 -> window bits 2..28 wrap to 0, giving track 0x0000_0000; CARRY_OUT=1; OVF=1. Then OVF_CLR -> OVF=0.
- Load 0x10, then SUB 0x10 -> 0x0; CARRY_OUT=1; OVF=0. Then SUB 0x4 -> 0x1FFF_FFFC; OVF=1 (borrow).
- USE_ALT=1, load 0x003F_FFFC, ADD 0x4 -> bits 2..21 clear, bit 22 unchanged (0), track 0x0; CARRY_OUT=1.
- Edge cases:
  - BLOCK_TOP=1 with LOAD 0x1000_0001 -> track 0x0000_0001.
  - SYNC at BIT_IDX=10 -> BIT_IDX=0 on the next cycle.
  - rst asserted mid-ADD -> track=INIT, OVF=0.
